// File: rtl/disp_scan.sv
// disp_scan: VGA raster timing, display-memory addressing and aligned symbol capture for a text screen.
// Build option DISP_SCAN_CURSOR_EN adds a blinking underline cursor at (cur_x, cur_y).
module disp_scan #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYM_W        = 8,
    parameter int SYM_H        = 16,
    parameter int COLS         = 80,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic [6:0]               disp_x,
    output logic [13:0]              disp_y,
    input  logic [7:0]               ascii,
    output logic [7:0]               ascii_q,
    output logic [$clog2(SYM_W)-1:0] glyph_col,
    output logic [$clog2(SYM_H)-1:0] glyph_row,
    output logic                     de,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     frame_start,
    input  logic [6:0]               cur_x,
    input  logic [4:0]               cur_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int GC_W    = $clog2(SYM_W);
    localparam int GR_W    = $clog2(SYM_H);

    localparam logic [HC_W-1:0] H_LAST_C   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] H_SS_C     = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] H_SE_C     = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST_C   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] V_SS_C     = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] V_SE_C     = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [GR_W-1:0] ROW_LAST_C = GR_W'(SYM_H - 1);
    localparam logic [13:0]     COLS_C     = 14'(COLS);

    logic [HC_W-1:0] h_cnt_q, h_cnt_d;
    logic [VC_W-1:0] v_cnt_q, v_cnt_d;
    logic [13:0]     row_base_q, row_base_d;
    logic            h_wrap_s, v_wrap_s, active_s;

    logic [6:0]      disp_x_q, disp_x_d;
    logic [13:0]     disp_y_q, disp_y_d;
    logic [GC_W-1:0] s0_col_q, s0_col_d;
    logic [GR_W-1:0] s0_row_q, s0_row_d;
    logic            s0_de_q, s0_de_d;
    logic            s0_hs_q, s0_hs_d;
    logic            s0_vs_q, s0_vs_d;
    logic            s0_fs_q, s0_fs_d;

    logic [7:0]      s1_ascii_q, s1_ascii_d;
    logic [GC_W-1:0] s1_col_q, s1_col_d;
    logic [GR_W-1:0] s1_row_q, s1_row_d;
    logic            s1_de_q, s1_de_d;
    logic            s1_hs_q, s1_hs_d;
    logic            s1_vs_q, s1_vs_d;
    logic            s1_fs_q, s1_fs_d;

`ifdef DISP_SCAN_CURSOR_EN
    localparam int              BF_W       = $clog2(BLINK_FRAMES + 1);
    localparam logic [BF_W-1:0] BF_LAST_C  = BF_W'(BLINK_FRAMES - 1);
    localparam logic [GR_W-1:0] ROW_UL_C   = GR_W'(SYM_H - 2);

    logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;
    logic [4:0]      s0_srow_q, s0_srow_d;
    logic            cur_hit_s;

    // Blink half-period counter and stage-1 cursor hit detection
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (h_wrap_s && v_wrap_s) begin
            if (blink_cnt_q == BF_LAST_C) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BF_W'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
        s0_srow_d = 5'(v_cnt_q >> GR_W);
        cur_hit_s = blink_on_q && s0_de_q && (disp_x_q == cur_x) &&
                    (s0_srow_q == cur_y) && (s0_row_q >= ROW_UL_C);
    end

    // Cursor state registers; blink starts in the visible phase
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            s0_srow_q   <= 5'd0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            s0_srow_q   <= s0_srow_d;
        end
    end
`else
    logic unused_cursor_s;
    assign unused_cursor_s = ^{cur_x, cur_y, (BLINK_FRAMES > 0)};
`endif

    // Raster counters, incremental row offset and both pipeline stages
    always_comb begin
        h_wrap_s = (h_cnt_q == H_LAST_C);
        v_wrap_s = (v_cnt_q == V_LAST_C);
        active_s = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

        if (h_wrap_s) begin
            h_cnt_d = '0;
            if (v_wrap_s) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VC_W'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HC_W'(1);
            v_cnt_d = v_cnt_q;
        end

        // Frame wrap must win over the per-row add on the very last line
        if (h_wrap_s && v_wrap_s) begin
            row_base_d = 14'd0;
        end else if (h_wrap_s && (v_cnt_q[GR_W-1:0] == ROW_LAST_C)) begin
            row_base_d = row_base_q + COLS_C;
        end else begin
            row_base_d = row_base_q;
        end

        if (active_s) begin
            disp_x_d = 7'(h_cnt_q >> GC_W);
            disp_y_d = row_base_q;
        end else begin
            disp_x_d = 7'd0;
            disp_y_d = 14'd0;
        end
        s0_col_d = h_cnt_q[GC_W-1:0];
        s0_row_d = v_cnt_q[GR_W-1:0];
        s0_de_d  = active_s;
        s0_hs_d  = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
        s0_vs_d  = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));
        s0_fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef DISP_SCAN_CURSOR_EN
        if (cur_hit_s) begin
            s1_ascii_d = 8'hDB;
        end else if (s0_de_q) begin
            s1_ascii_d = ascii;
        end else begin
            s1_ascii_d = 8'h00;
        end
`else
        if (s0_de_q) begin
            s1_ascii_d = ascii;
        end else begin
            s1_ascii_d = 8'h00;
        end
`endif
        s1_col_d = s0_col_q;
        s1_row_d = s0_row_q;
        s1_de_d  = s0_de_q;
        s1_hs_d  = s0_hs_q;
        s1_vs_d  = s0_vs_q;
        s1_fs_d  = s0_fs_q;
    end

    // State and pipeline registers; syncs idle high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            row_base_q <= 14'd0;
            disp_x_q   <= 7'd0;
            disp_y_q   <= 14'd0;
            s0_col_q   <= '0;
            s0_row_q   <= '0;
            s0_de_q    <= 1'b0;
            s0_hs_q    <= 1'b1;
            s0_vs_q    <= 1'b1;
            s0_fs_q    <= 1'b0;
            s1_ascii_q <= 8'h00;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_de_q    <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s1_fs_q    <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            row_base_q <= row_base_d;
            disp_x_q   <= disp_x_d;
            disp_y_q   <= disp_y_d;
            s0_col_q   <= s0_col_d;
            s0_row_q   <= s0_row_d;
            s0_de_q    <= s0_de_d;
            s0_hs_q    <= s0_hs_d;
            s0_vs_q    <= s0_vs_d;
            s0_fs_q    <= s0_fs_d;
            s1_ascii_q <= s1_ascii_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s1_de_q    <= s1_de_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_fs_q    <= s1_fs_d;
        end
    end

    assign disp_x      = disp_x_q;
    assign disp_y      = disp_y_q;
    assign ascii_q     = s1_ascii_q;
    assign glyph_col   = s1_col_q;
    assign glyph_row   = s1_row_q;
    assign de          = s1_de_q;
    assign hsync       = s1_hs_q;
    assign vsync       = s1_vs_q;
    assign frame_start = s1_fs_q;

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: a full-size instance (ascii tied to 0x41) and a shrunken-timing instance
// (memory returns (disp_x+disp_y)&0xFF), both checked every cycle against a position-based model.
module tb_disp_scan;

    localparam int CUR_X_DEF = 5;
    localparam int CUR_Y_DEF = 1;
    localparam int CUR_X_SML = 5;
    localparam int CUR_Y_SML = 3;
    localparam int BF_DEF    = 30;
    localparam int BF_SML    = 2;

    logic        clk;
    logic        rst_def_n, rst_sml_n;
    logic [6:0]  dx_def, dx_sml;
    logic [13:0] dy_def, dy_sml;
    logic [7:0]  asc_def, asc_sml, aq_def, aq_sml;
    logic [2:0]  gc_def, gc_sml;
    logic [3:0]  gr_def, gr_sml;
    logic        de_def, de_sml, hs_def, hs_sml, vs_def, vs_sml, fs_def, fs_sml;
    logic [13:0] mem_sum;

    int k_def, k_sml;
    int total_cnt, bad_cnt;
    bit chk_en;

    assign asc_def = 8'h41;
    assign mem_sum = {7'd0, dx_sml} + dy_sml;
    assign asc_sml = mem_sum[7:0];

    disp_scan #(.BLINK_FRAMES(BF_DEF)) u_def (
        .clk(clk), .resetn(rst_def_n), .disp_x(dx_def), .disp_y(dy_def),
        .ascii(asc_def), .ascii_q(aq_def), .glyph_col(gc_def), .glyph_row(gr_def),
        .de(de_def), .hsync(hs_def), .vsync(vs_def), .frame_start(fs_def),
        .cur_x(7'(CUR_X_DEF)), .cur_y(5'(CUR_Y_DEF))
    );

    disp_scan #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(64), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYM_W(8), .SYM_H(16), .COLS(8), .BLINK_FRAMES(BF_SML)
    ) u_sml (
        .clk(clk), .resetn(rst_sml_n), .disp_x(dx_sml), .disp_y(dy_sml),
        .ascii(asc_sml), .ascii_q(aq_sml), .glyph_col(gc_sml), .glyph_row(gr_sml),
        .de(de_sml), .hsync(hs_sml), .vsync(vs_sml), .frame_start(fs_sml),
        .cur_x(7'(CUR_X_SML)), .cur_y(5'(CUR_Y_SML))
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since each reset release
    always @(posedge clk or negedge rst_def_n) begin
        if (!rst_def_n) k_def <= 0;
        else            k_def <= k_def + 1;
    end
    always @(posedge clk or negedge rst_sml_n) begin
        if (!rst_sml_n) k_sml <= 0;
        else            k_sml <= k_sml + 1;
    end

    // Expected {disp_x, disp_y, ascii_q, glyph_col, glyph_row, de, hsync, vsync, frame_start}
    // after k edges; the address stage shows scan position k-1, the output stage position k-2.
    function automatic logic [39:0] model(input int inst, input int k);
        int hact, hfp, hsy, hbp, vact, vfp, vsy, vbp, cols, bf, cx, cy;
        int ht, vt, p, x, y, f, cod;
        logic [6:0]  ex;
        logic [13:0] ey;
        logic [7:0]  ea;
        logic [2:0]  egc;
        logic [3:0]  egr;
        logic        ede, ehs, evs, efs;
        if (inst == 0) begin
            hact = 640; hfp = 16; hsy = 96; hbp = 48;
            vact = 480; vfp = 10; vsy = 2;  vbp = 33;
            cols = 80;  bf = BF_DEF; cx = CUR_X_DEF; cy = CUR_Y_DEF;
        end else begin
            hact = 64; hfp = 4; hsy = 8; hbp = 4;
            vact = 64; vfp = 2; vsy = 2; vbp = 2;
            cols = 8;  bf = BF_SML; cx = CUR_X_SML; cy = CUR_Y_SML;
        end
        ht = hact + hfp + hsy + hbp;
        vt = vact + vfp + vsy + vbp;
        ex = 7'd0; ey = 14'd0;
        if (k >= 1) begin
            p = k - 1; x = p % ht; y = (p / ht) % vt;
            if (x < hact && y < vact) begin
                ex = 7'(x / 8);
                ey = 14'((y / 16) * cols);
            end
        end
        ea = 8'h00; egc = 3'd0; egr = 4'd0; ede = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
        if (k >= 2) begin
            p = k - 2; x = p % ht; y = (p / ht) % vt; f = p / (ht * vt);
            egc = 3'(x % 8);
            egr = 4'(y % 16);
            ede = (x < hact) && (y < vact);
            ehs = !(x >= hact + hfp && x < hact + hfp + hsy);
            evs = !(y >= vact + vfp && y < vact + vfp + vsy);
            efs = (x == 0) && (y == 0);
            if (ede) begin
                cod = (inst == 0) ? 'h41 : ((x / 8 + (y / 16) * cols) & 255);
`ifdef DISP_SCAN_CURSOR_EN
                if (((f / bf) % 2) == 0 && x / 8 == cx && y / 16 == cy && y % 16 >= 14) cod = 'hDB;
`endif
                ea = 8'(cod);
            end
        end
        return {ex, ey, ea, egc, egr, ede, ehs, evs, efs};
    endfunction

    task automatic check(input string name, input int k, input logic [39:0] act, input logic [39:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, req);
            if (bad_cnt >= 50) begin
                $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
                $finish;
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("scan_def", k_def,
                  {dx_def, dy_def, aq_def, gc_def, gr_def, de_def, hs_def, vs_def, fs_def},
                  model(0, k_def));
            check("scan_sml", k_sml,
                  {dx_sml, dy_sml, aq_sml, gc_sml, gr_sml, de_sml, hs_sml, vs_sml, fs_sml},
                  model(1, k_sml));
        end
    end

    task automatic wait_def(input int n);
        while (k_def < n) @(negedge clk);
    endtask

    task automatic wait_sml(input int n);
        while (k_sml < n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] cur_sml, cur_def;
`ifdef DISP_SCAN_CURSOR_EN
        cur_sml = 8'hDB;
        cur_def = 8'hDB;
`else
        cur_sml = 8'h1D;
        cur_def = 8'h41;
`endif
        total_cnt = 0; bad_cnt = 0; chk_en = 1'b0;
        rst_def_n = 1'b0; rst_sml_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hsync", 0, 40'(hs_def), 40'd1);
        check("rst_vsync", 0, 40'(vs_def), 40'd1);
        check("rst_de", 0, 40'(de_def), 40'd0);
        check("rst_ascii_q", 0, 40'(aq_def), 40'd0);
        @(negedge clk);
        #2;
        rst_def_n = 1'b1; rst_sml_n = 1'b1;

        wait_def(1);     check("k1_de", k_def, 40'(de_def), 40'd0);
                         check("k1_disp_y", k_def, 40'(dy_def), 40'd0);
        wait_def(2);     check("k2_de", k_def, 40'(de_def), 40'd1);
                         check("k2_ascii_q", k_def, 40'(aq_def), 40'h41);
                         check("k2_glyph", k_def, 40'({gc_def, gr_def}), 40'd0);
                         check("k2_frame_start", k_def, 40'(fs_def), 40'd1);
        wait_def(3);     check("k3_frame_start", k_def, 40'(fs_def), 40'd0);
                         check("k3_glyph_col", k_def, 40'(gc_def), 40'd1);
        wait_def(9);     check("k9_disp_x", k_def, 40'(dx_def), 40'd1);
        wait_def(640);   check("last_col_disp_x", k_def, 40'(dx_def), 40'd79);
        wait_def(641);   check("hblank_disp_x", k_def, 40'(dx_def), 40'd0);
        wait_def(657);   check("hsync_before", k_def, 40'(hs_def), 40'd1);
        wait_def(658);   check("hsync_first", k_def, 40'(hs_def), 40'd0);
        wait_def(753);   check("hsync_last", k_def, 40'(hs_def), 40'd0);
        wait_def(754);   check("hsync_after", k_def, 40'(hs_def), 40'd1);
        wait_sml(5002);  check("sml_cursor_f0", k_sml, 40'(aq_sml), 40'(cur_sml));
        wait_sml(5104);  check("sml_last_sym", k_sml, 40'({dx_sml, dy_sml}), 40'({7'd7, 14'd24}));
        wait_sml(5281);  check("sml_vsync_before", k_sml, 40'(vs_sml), 40'd1);
        wait_sml(5282);  check("sml_vsync_first", k_sml, 40'(vs_sml), 40'd0);
        wait_sml(5601);  check("sml_wrap_disp_y", k_sml, 40'(dy_sml), 40'd0);
        wait_sml(6881);  check("sml_row1_disp_y", k_sml, 40'(dy_sml), 40'd8);
        wait_sml(10602); check("sml_cursor_f1", k_sml, 40'(aq_sml), 40'(cur_sml));
        wait_def(12800); check("line15_end_disp_y", k_def, 40'(dy_def), 40'd0);
        wait_def(12801); check("line16_disp_y", k_def, 40'(dy_def), 40'd80);
        wait_def(13440); check("line16_last", k_def, 40'({dx_def, dy_def}), 40'({7'd79, 14'd80}));
        wait_sml(16202); check("sml_cursor_f2_off", k_sml, 40'(aq_sml), 40'h1D);
        wait_def(24042); check("def_cursor", k_def, 40'(aq_def), 40'(cur_def));

        // Mid-frame reset of the small instance at line 40, pixel 30 of frame 4
        wait_sml(25630);
        #2;
        rst_sml_n = 1'b0;
        @(negedge clk);
        check("mid_rst_sync", 0, 40'({hs_sml, vs_sml}), 40'd3);
        check("mid_rst_de", 0, 40'(de_sml), 40'd0);
        check("mid_rst_disp_y", 0, 40'(dy_sml), 40'd0);
        repeat (4) @(negedge clk);
        #2;
        rst_sml_n = 1'b1;
        wait_sml(1);     check("restart_addr", k_sml, 40'({dx_sml, dy_sml}), 40'd0);
        wait_sml(2);     check("restart_frame_start", k_sml, 40'({de_sml, fs_sml}), 40'd3);
        wait_sml(3);     check("restart_fs_pulse", k_sml, 40'(fs_sml), 40'd0);
        wait_sml(41);    check("restart_line0", k_sml, 40'({dx_sml, dy_sml}), 40'({7'd5, 14'd0}));
        wait_sml(5700);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
